// File: rtl/pg_pkg.sv
// pg_pkg: shared types for the generate/propagate pre-processing stage.
//   PG_WIDTH_DEF : default operand width
//   pg_state_e   : main/skid occupancy state
//   pg_fold_g0   : folds the carry-in into the bit-0 generate term
package pg_pkg;

    localparam int PG_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pg_state_e;

    // A bit-0 carry-in acts as a generate term wherever bit 0 propagates.
    function automatic logic pg_fold_g0(input logic g_raw, input logic p_raw, input logic cin_eff);
        return g_raw | (p_raw & cin_eff);
    endfunction

endpackage

// File: rtl/pg_bitcell.sv
// pg_bitcell: one-bit generate/propagate cell (combinational).
//   a, b : operand bits
//   g    : generate, a & b
//   p    : propagate, a ^ b (XOR form, so the sum stage can reuse it)
module pg_bitcell (
    input  logic a,
    input  logic b,
    output logic g,
    output logic p
);

    assign g = a & b;
    assign p = a ^ b;

endmodule

// File: rtl/pg_gen_stage.sv
// pg_gen_stage: registers A/B/cin behind a valid/ready handshake and presents
// per-bit generate/propagate vectors to the prefix tree, with the carry-in
// folded into g[0]. A main register plus one skid register give full
// throughput while in_ready stays a pure function of registered state.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_ready  : upstream handshake (in_ready registered)
//   a, b, cin           : operands and carry-in
//   sub                 : subtract select (only with PG_SUB_EN defined)
//   out_valid, out_ready: downstream handshake to the prefix tree
//   g, p, c0            : generate, propagate, effective carry-in
//
// Build option: define PG_SUB_EN to add the sub port (A-B via ~B and cin=1).
//
// state | meaning
// ------+---------------------------------------------------
// EMPTY | nothing held; out_valid=0, in_ready=1
// ONE   | main register holds a word; out_valid=1, in_ready=1
// TWO   | main and skid both full; out_valid=1, in_ready=0
module pg_gen_stage
    import pg_pkg::*;
#(
    parameter int WIDTH = PG_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PG_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] g,
    output logic [WIDTH-1:0] p,
    output logic             c0
);

    typedef logic [WIDTH-1:0] pg_vec_t;

    typedef struct packed {
        pg_vec_t g;
        pg_vec_t p;
        logic    c0;
    } pg_word_t;

    pg_state_e state;
    pg_state_e state_nxt;
    pg_word_t  main_q;
    pg_word_t  skid_q;
    pg_word_t  in_word;
    pg_vec_t   b_eff;
    pg_vec_t   g_raw;
    pg_vec_t   p_raw;
    logic      cin_eff;
    logic      in_xfer;
    logic      out_xfer;
    logic      load_main;
    logic      load_skid;
    logic      move_skid;

`ifdef PG_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin & ~sub;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_cells
        pg_bitcell u_cell (
            .a (a[i]),
            .b (b_eff[i]),
            .g (g_raw[i]),
            .p (p_raw[i])
        );
    end

    always_comb begin
        in_word    = '0;
        in_word.p  = p_raw;
        in_word.g  = {g_raw[WIDTH-1:1], pg_fold_g0(g_raw[0], p_raw[0], cin_eff)};
        in_word.c0 = cin_eff;
    end

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_xfer) begin
                    load_main = 1'b1;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    load_main = 1'b1;
                end else if (in_xfer) begin
                    load_skid = 1'b1;
                    state_nxt = TWO;
                end else if (out_xfer) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    move_skid = 1'b1;
                    state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state == ONE) || (state == TWO);
        in_ready  = (state != TWO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= in_word;
            end else if (move_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_word;
            end
        end
    end

    assign g  = main_q.g;
    assign p  = main_q.p;
    assign c0 = main_q.c0;

endmodule

// File: tb/tb_pg_gen_stage.sv
// tb_pg_gen_stage: scoreboard bench for pg_gen_stage. The driver pushes the
// expected g/p/c0 word when an input transfer happens; an independent monitor
// compares every presented output against the queue head and pops on transfer.
module tb_pg_gen_stage;

    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] g;
        logic [W-1:0] p;
        logic         c0;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] g;
        logic [W-1:0] p;
        logic         c0;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_s;
    logic [W-1:0] b_s;
    logic         cin_s;
    logic         sub_s;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] g;
    logic [W-1:0] p;
    logic         c0;

    exp_t sb[$];
    int   checks;
    int   errors;
    int   n_out;
    int   cyc;
    int   stall_cnt;
    bit   stream_mode;

    pg_gen_stage #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_s),
        .b         (b_s),
        .cin       (cin_s),
`ifdef PG_SUB_EN
        .sub       (sub_s),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .g         (g),
        .p         (p),
        .c0        (c0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Hand-computed directed vectors: a, b, cin -> g, p, c0
    vec_t dir_vecs[6];
    initial begin
        dir_vecs[0] = '{32'h0000_000F, 32'h0000_0001, 1'b0, 32'h0000_0001, 32'h0000_000E, 1'b0};
        dir_vecs[1] = '{32'h0000_0001, 32'h0000_0000, 1'b1, 32'h0000_0001, 32'h0000_0001, 1'b1};
        dir_vecs[2] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1};
        dir_vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1};
        dir_vecs[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 32'h0000_0000, 1'b0};
        dir_vecs[5] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1};
    end

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic cv, input logic sv);
        exp_t         e;
        logic [W-1:0] bb;
        logic         ce;
        bb = sv ? ~bv : bv;
        ce = sv ? 1'b1 : cv;
        e.p = av ^ bb;
        e.g = av & bb;
        if (e.p[0] && ce) e.g[0] = 1'b1;
        e.c0 = ce;
        return e;
    endfunction

    // Monitor: any presented word must match the queue head; pop on transfer.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got g=%h p=%h c0=%b, required no output", g, p, c0);
            end else begin
                if (g !== sb[0].g || p !== sb[0].p || c0 !== sb[0].c0) begin
                    errors++;
                    $display("FAIL out_word: got g=%h p=%h c0=%b, required g=%h p=%h c0=%b",
                             g, p, c0, sb[0].g, sb[0].p, sb[0].c0);
                end
                if (out_ready) begin
                    void'(sb.pop_front());
                    n_out++;
                end
            end
        end
    end

    task automatic check1(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv, input exp_t ev);
        bit done;
        done     = 1'b0;
        a_s      = av;
        b_s      = bv;
        cin_s    = cv;
        sub_s    = sv;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(ev);
                done = 1'b1;
            end else if (stream_mode) begin
                stall_cnt++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for 200 cycles, required acceptance");
        end
    endtask

    task automatic send_vec(input int i);
        exp_t ev;
        ev.g  = dir_vecs[i].g;
        ev.p  = dir_vecs[i].p;
        ev.c0 = dir_vecs[i].c0;
        send(dir_vecs[i].a, dir_vecs[i].b, dir_vecs[i].cin, 1'b0, ev);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d words pending, required 0", sb.size());
        end
    endtask

    initial begin
        int   cyc0;
        int   nout0;
        exp_t ev;

        checks      = 0;
        errors      = 0;
        n_out       = 0;
        cyc         = 0;
        stall_cnt   = 0;
        stream_mode = 1'b0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        a_s         = '0;
        b_s         = '0;
        cin_s       = 1'b0;
        sub_s       = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check1("reset_out_valid", {31'b0, out_valid}, 32'h0);
        check1("reset_in_ready", {31'b0, in_ready}, 32'h1);
        check1("reset_g", g, 32'h0);
        check1("reset_p", p, 32'h0);
        check1("reset_c0", {31'b0, c0}, 32'h0);
        @(posedge clk);
        #1;

        // Single op and one-cycle latency
        send_vec(0);
        check1("latency_out_valid", {31'b0, out_valid}, 32'h1);
        idle();
        drain();

        // Carry-in folding
        send_vec(1);
        send_vec(2);
        idle();
        drain();

        // Backpressure: three back-to-back inputs with out_ready low
        out_ready = 1'b0;
        fork
            begin
                send_vec(3);
                send_vec(4);
                send_vec(5);
                idle();
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                check1("bp_in_ready_low", {31'b0, in_ready}, 32'h0);
                check1("bp_out_valid", {31'b0, out_valid}, 32'h1);
                check1("bp_pending", sb.size(), 32'd2);
                out_ready = 1'b1;
            end
        join
        drain();

        // Streaming: 100 random ops with out_ready high
        nout0       = n_out;
        stall_cnt   = 0;
        stream_mode = 1'b1;
        cyc0        = cyc;
        for (int i = 0; i < 100; i++) begin
            logic [W-1:0] av;
            logic [W-1:0] bv;
            logic         cv;
            av = $urandom;
            bv = $urandom;
            cv = 1'($urandom_range(0, 1));
            send(av, bv, cv, 1'b0, model(av, bv, cv, 1'b0));
        end
        stream_mode = 1'b0;
        check1("stream_cycles", cyc - cyc0, 32'd100);
        check1("stream_stalls", stall_cnt, 32'd0);
        idle();
        drain();
        check1("stream_outputs", n_out - nout0, 32'd100);

        // Reset while in TWO
        out_ready = 1'b0;
        send_vec(3);
        send_vec(4);
        idle();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check1("rst_mid_out_valid", {31'b0, out_valid}, 32'h0);
        check1("rst_mid_in_ready", {31'b0, in_ready}, 32'h1);
        sb.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check1("post_rst_quiet", {31'b0, out_valid}, 32'h0);
        end
        @(posedge clk);
        #1;
        send_vec(5);
        idle();
        drain();

`ifdef PG_SUB_EN
        ev.g  = 32'h0000_0005;
        ev.p  = 32'hFFFF_FFF9;
        ev.c0 = 1'b1;
        send(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, ev);
        ev.g  = 32'h0000_0001;
        ev.p  = 32'h0000_0006;
        ev.c0 = 1'b1;
        send(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, ev);
        idle();
        drain();
`else
        ev = model(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0);
        send(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, ev);
        idle();
        drain();
`endif

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
